// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and RAM-side signals around mem_arbiter.
// The arbiter uses the slave modport; the requesters/RAM side uses master.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   // instruction-fetch port (read-only)
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rsp_valid;
   logic              if_rsp_ready;
   logic [DATA_W-1:0] if_rsp_data;

   // load/store port
   logic              d_req_valid;
   logic              d_req_ready;
   logic [ADDR_W-1:0] d_addr;
   logic              d_we;
   logic [BE_W-1:0]   d_be;
   logic [DATA_W-1:0] d_wdata;
   logic              d_rsp_valid;
   logic              d_rsp_ready;
   logic [DATA_W-1:0] d_rsp_data;

   // single-port RAM
   logic [ADDR_W-1:0] mem_addr;
   logic [BE_W-1:0]   mem_be;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req_valid, if_addr, if_rsp_ready,
      output d_req_valid, d_addr, d_we, d_be, d_wdata, d_rsp_ready,
      output mem_rdata,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      input  d_req_ready, d_rsp_valid, d_rsp_data,
      input  mem_addr, mem_be, mem_wdata
   );

   modport slave (
      input  if_req_valid, if_addr, if_rsp_ready,
      input  d_req_valid, d_addr, d_we, d_be, d_wdata, d_rsp_ready,
      input  mem_rdata,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      output d_req_ready, d_rsp_valid, d_rsp_data,
      output mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter and sequencer in front of a single-port word RAM.
// One outstanding transaction: IDLE (accept) -> ACCESS (one RAM cycle) -> RESP (hold until taken).
module mem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           rst_n,
   mem_arbiter_if.slave  bus
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic              is_data;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            state_q, state_d;
   req_t              req_q, req_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [DATA_W-1:0] if_data_q, d_data_q;
   logic              grant_if, grant_d;

   // Data wins ties unless fetch has lost LIMIT arbitrations in a row.
   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (rst_n && (state_q == IDLE)) begin
         if (bus.if_req_valid && (!bus.d_req_valid || (starve_q == LIMIT))) begin
            grant_if = 1'b1;
         end else if (bus.d_req_valid) begin
            grant_d = 1'b1;
         end
      end
   end

   // Next state and request latch contents.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      unique case (state_q)
         IDLE: begin
            if (grant_if) begin
               req_d.is_data = 1'b0;
               req_d.we      = 1'b0;
               req_d.be      = '0;
               req_d.addr    = bus.if_addr;
               req_d.wdata   = '0;
               state_d       = ACCESS;
            end else if (grant_d) begin
               req_d.is_data = 1'b1;
               req_d.we      = bus.d_we;
               req_d.be      = bus.d_be;
               req_d.addr    = bus.d_addr;
               req_d.wdata   = bus.d_wdata;
               state_d       = ACCESS;
            end
         end
         ACCESS: begin
            state_d = RESP;
         end
         RESP: begin
            if (req_q.is_data ? bus.d_rsp_ready : bus.if_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Starvation counter: clears whenever fetch is idle or wins.
   always_comb begin
      starve_d = starve_q;
      if (!bus.if_req_valid || grant_if) begin
         starve_d = '0;
      end else if (grant_d && (starve_q != LIMIT)) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         req_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         starve_q <= starve_d;
      end
   end

   // RAM read data lands in the granted port's response register at the end of ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_data_q <= '0;
         d_data_q  <= '0;
      end else if (state_q == ACCESS) begin
         if (req_q.is_data) begin
            d_data_q <= bus.mem_rdata;
         end else begin
            if_data_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.if_req_ready = grant_if;
   assign bus.d_req_ready  = grant_d;
   assign bus.if_rsp_valid = (state_q == RESP) && !req_q.is_data;
   assign bus.d_rsp_valid  = (state_q == RESP) &&  req_q.is_data;
   assign bus.if_rsp_data  = if_data_q;
   assign bus.d_rsp_data   = d_data_q;

   // Byte enables only during the ACCESS cycle of a data write.
   assign bus.mem_addr  = req_q.addr;
   assign bus.mem_wdata = req_q.wdata;
   assign bus.mem_be    = ((state_q == ACCESS) && req_q.is_data && req_q.we) ? req_q.be : '0;

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.if_req_ready && bus.d_req_ready));
   a_be_only_access: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != ACCESS) |-> (bus.mem_be == '0));
   a_be_never_fetch: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.mem_be != '0) |-> req_q.is_data);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected responses, a monitor pops and compares.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   logic ram_init;
   int   errors = 0;
   int   checks = 0;

   logic [31:0] ram [0:63];
   logic [31:0] if_q[$];
   logic [31:0] d_q[$];

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Bench RAM: combinational read, byte-enabled write on the rising edge.
   assign bus.mem_rdata = ram[bus.mem_addr[7:2]];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 64; i++) ram[i] <= 32'(i);
         ram[4] <= 32'h00A00093;
         ram[8] <= 32'h11223344;
         ram[9] <= 32'h55667788;
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: every handshake pops the matching expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.if_rsp_valid && bus.if_rsp_ready) begin
            if (if_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL if_rsp unexpected: got %h expected none", bus.if_rsp_data);
            end else check("if_rsp_data", 64'(bus.if_rsp_data), 64'(if_q.pop_front()));
         end
         if (bus.d_rsp_valid && bus.d_rsp_ready) begin
            if (d_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL d_rsp unexpected: got %h expected none", bus.d_rsp_data);
            end else check("d_rsp_data", 64'(bus.d_rsp_data), 64'(d_q.pop_front()));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((if_q.size() != 0 || d_q.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL wait_idle: got %0d pending responses expected 0", if_q.size() + d_q.size());
      end
      @(posedge clk); #1;
   endtask

   // Single request with accept / ACCESS / RESP timing checks.
   task automatic do_req(input bit is_d, input logic [31:0] addr, input bit we,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] exp, input string tag);
      int n = 0;
      bit got = 1'b0;
      if (is_d) begin
         bus.d_req_valid = 1'b1; bus.d_addr = addr; bus.d_we = we;
         bus.d_be = be; bus.d_wdata = wdata;
      end else begin
         bus.if_req_valid = 1'b1; bus.if_addr = addr;
      end
      while (!got && n < 20) begin
         @(negedge clk);
         got = is_d ? bus.d_req_ready : bus.if_req_ready;
         n++;
      end
      check({tag, " accept"}, 64'(got), 64'(1));
      check({tag, " be idle"}, 64'(bus.mem_be), 64'(0));
      if (is_d) d_q.push_back(exp); else if_q.push_back(exp);
      @(posedge clk); #1;
      bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;
      @(negedge clk);
      check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'(addr));
      check({tag, " mem_be"}, 64'(bus.mem_be), 64'((is_d && we) ? be : 4'h0));
      @(negedge clk);
      check({tag, " rsp_valid"}, 64'(is_d ? bus.d_rsp_valid : bus.if_rsp_valid), 64'(1));
      check({tag, " be resp"}, 64'(bus.mem_be), 64'(0));
      wait_idle();
   endtask

   // Both ports held valid; LIMIT=4 gives D,D,D,D,I repeating.
   task automatic grant_seq(input int n);
      int g = 0;
      int cyc = 0;
      bit isd;
      while (g < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.if_req_ready || bus.d_req_ready) begin
            check("grant onehot", 64'(bus.if_req_ready && bus.d_req_ready), 64'(0));
            isd = bus.d_req_ready;
            check($sformatf("grant %0d is data", g), 64'(isd), 64'((g % 5) != 4));
            if (isd) d_q.push_back(32'h1122BEEF); else if_q.push_back(32'h00A00093);
            g++;
         end
      end
      if (g < n) begin
         checks++; errors++;
         $display("FAIL grant_seq: got %0d grants expected %0d", g, n);
      end
      @(posedge clk); #1;
      bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ram_init = 1'b1;
      bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.if_rsp_ready = 1'b1;
      bus.d_req_valid = 1'b0; bus.d_addr = '0; bus.d_we = 1'b0; bus.d_be = '0;
      bus.d_wdata = '0; bus.d_rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 ram_init = 1'b0;

      // reset state
      @(negedge clk);
      check("rst if_req_ready", 64'(bus.if_req_ready), 64'(0));
      check("rst d_req_ready", 64'(bus.d_req_ready), 64'(0));
      check("rst if_rsp_valid", 64'(bus.if_rsp_valid), 64'(0));
      check("rst d_rsp_valid", 64'(bus.d_rsp_valid), 64'(0));
      check("rst if_rsp_data", 64'(bus.if_rsp_data), 64'(0));
      check("rst d_rsp_data", 64'(bus.d_rsp_data), 64'(0));
      check("rst mem_addr", 64'(bus.mem_addr), 64'(0));
      check("rst mem_be", 64'(bus.mem_be), 64'(0));
      check("rst mem_wdata", 64'(bus.mem_wdata), 64'(0));
      @(posedge clk); #1 rst_n = 1'b1;

      do_req(1'b0, 32'h10, 1'b0, 4'h0, 32'h0, 32'h00A00093, "fetch10");
      do_req(1'b1, 32'h20, 1'b1, 4'b0011, 32'hDEADBEEF, 32'h11223344, "wr20");
      do_req(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 32'h1122BEEF, "rd20");
      do_req(1'b1, 32'h24, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h55667788, "wr24_be0");
      do_req(1'b1, 32'h24, 1'b0, 4'h0, 32'h0, 32'h55667788, "rd24");
      do_req(1'b0, 32'h13, 1'b0, 4'h0, 32'h0, 32'h00A00093, "fetch13");
      do_req(1'b1, 32'h22, 1'b0, 4'h0, 32'h0, 32'h1122BEEF, "rd22");

      // starvation pattern
      bus.if_addr = 32'h10; bus.d_addr = 32'h20; bus.d_we = 1'b0;
      bus.if_req_valid = 1'b1; bus.d_req_valid = 1'b1;
      grant_seq(10);

      // response stall with a pending fetch
      bus.d_req_valid = 1'b1; bus.d_addr = 32'h20; bus.d_we = 1'b0; bus.d_rsp_ready = 1'b0;
      @(negedge clk);
      check("stall accept", 64'(bus.d_req_ready), 64'(1));
      d_q.push_back(32'h1122BEEF);
      @(posedge clk); #1;
      bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b1; bus.if_addr = 32'h10;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall d_rsp_valid", 64'(bus.d_rsp_valid), 64'(1));
         check("stall d_rsp_data", 64'(bus.d_rsp_data), 64'(32'h1122BEEF));
         check("stall no ready", 64'(bus.if_req_ready || bus.d_req_ready), 64'(0));
      end
      @(posedge clk); #1 bus.d_rsp_ready = 1'b1;
      @(negedge clk);
      check("stall release no ready", 64'(bus.if_req_ready), 64'(0));
      @(negedge clk);
      check("idle after release", 64'(bus.if_req_ready), 64'(1));
      if_q.push_back(32'h00A00093);
      @(posedge clk); #1 bus.if_req_valid = 1'b0;
      wait_idle();

      // reset during ACCESS of a write, with fetch losing once beforehand
      bus.if_req_valid = 1'b1; bus.if_addr = 32'h10;
      bus.d_req_valid = 1'b1; bus.d_addr = 32'h24; bus.d_we = 1'b1;
      bus.d_be = 4'hF; bus.d_wdata = 32'hCAFEF00D;
      @(negedge clk);
      check("rstacc d accept", 64'(bus.d_req_ready), 64'(1));
      check("rstacc if wait", 64'(bus.if_req_ready), 64'(0));
      @(posedge clk); #1;
      bus.d_req_valid = 1'b0;
      check("rstacc be access", 64'(bus.mem_be), 64'(4'hF));
      #2 rst_n = 1'b0;
      #1;
      check("rstacc be dropped", 64'(bus.mem_be), 64'(0));
      check("rstacc addr dropped", 64'(bus.mem_addr), 64'(0));
      check("rstacc wdata dropped", 64'(bus.mem_wdata), 64'(0));
      check("rstacc if_req_ready", 64'(bus.if_req_ready), 64'(0));
      @(posedge clk); #1;
      check("rstacc ram kept", 64'(ram[9]), 64'(32'h55667788));
      check("rstacc no rsp", 64'(bus.d_rsp_valid), 64'(0));
      bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_req_valid = 1'b1;
      rst_n = 1'b1;
      grant_seq(5);

      check("if queue drained", 64'(if_q.size()), 64'(0));
      check("d queue drained", 64'(d_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port word RAM (combinational read, byte-enabled synchronous write).
- Shares the RAM between the instruction-fetch port (read-only) and the load/store port (read/write with byte enables).
- Latches each accepted request, drives the RAM for exactly one cycle, and returns a registered response with valid/ready backpressure.
- Sits between the core's fetch/LSU stages and the RAM.

Parameters:
- ADDR_W, 32, request/RAM address width.
- DATA_W, 32, data width (byte enables = DATA_W/8).
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch is forced to win (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req_valid  input  1  fetch request valid.
- if_req_ready  output  1  fetch request accepted this cycle.
- if_addr  input  ADDR_W  fetch byte address.
- if_rsp_valid  output  1  fetch response valid.
- if_rsp_ready  input  1  fetch consumer ready.
- if_rsp_data  output  DATA_W  fetched word.
- d_req_valid  input  1  data request valid.
- d_req_ready  output  1  data request accepted this cycle.
- d_addr  input  ADDR_W  data byte address.
- d_we  input  1  1 = write, 0 = read.
- d_be  input  DATA_W/8  write byte enables.
- d_wdata  input  DATA_W  write data.
- d_rsp_valid  output  1  data response valid.
- d_rsp_ready  input  1  data consumer ready.
- d_rsp_data  output  DATA_W  read word (pre-write word for writes).
- mem_addr  output  ADDR_W  RAM address.
- mem_be  output  DATA_W/8  RAM byte write enables.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM combinational read data.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; starvation counter = 0.
  - All valid/ready outputs 0; rsp_data = 0.
  - mem_be = 0, mem_addr = 0, mem_wdata = 0, all taking effect immediately.
  - Any in-flight transaction is dropped with no response.
- FSM IDLE → ACCESS → RESP → IDLE:
  - IDLE: arbitrate among valid requests. The winner's req_ready = 1 for that cycle (combinational from the valids while in IDLE; 0 in every other state). The winner's addr/we/be/wdata and a grant-id register are latched at the edge; next state = ACCESS. No request: stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - mem_addr and mem_wdata come from the latched request.
    - mem_be = latched be if the latched request is a data write, else 0.
    - mem_rdata is captured into the granted port's rsp_data register at the edge; next state = RESP.
  - RESP: the granted port's rsp_valid = 1 and rsp_data is held stable. Leave for IDLE when rsp_valid & rsp_ready; otherwise hold.
- Latency: accept at edge N; RAM access in cycle N+1; rsp_valid from cycle N+2. Minimum 3 cycles per transaction; one outstanding transaction only.
- Arbitration:
  - Data wins ties by default.
  - Starvation counter increments (saturating at STARVE_LIMIT) on each IDLE arbitration cycle where fetch is valid but data is granted.
  - When the counter equals STARVE_LIMIT and both are valid, fetch wins.
  - Counter clears on a fetch grant or any cycle fetch is not valid.
- mem_be is 0 in IDLE and RESP and for all reads; it is never nonzero for fetch transactions.
- Write with d_be = 0: full transaction, no RAM byte changes, response still returned.
- Address bits [1:0] pass through unmodified; there is no alignment check.
- Request inputs are sampled only in the IDLE accept cycle; later changes are ignored.
- Outside RESP, rsp_data of the non-granted port holds its last value.

Test Plan:
- Reset → every output is 0.
- Release reset; fetch read of addr 0x10 with RAM word 4 = 0x00A00093 → if_req_ready=1 in cycle N, mem_addr=0x10 and mem_be=0 in N+1, if_rsp_valid=1 with data 0x00A00093 in N+2.
- Data write addr 0x20, be=4'b0011, wdata=0xDEADBEEF over prior word 0x11223344 → mem_be=0011 for exactly one cycle, d_rsp_data=0x11223344; a following read returns 0x1122BEEF.
- Both ports valid continuously, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I…
- Hold d_rsp_ready=0 for 5 cycles after a read → d_rsp_valid and d_rsp_data stay stable; no new req_ready during the stall; IDLE is entered the cycle after ready rises.
- Assert rst_n=0 during ACCESS of a write → mem_be drops to 0 immediately; no response is issued; after release, state is IDLE and the counter is 0.
